vga_frame_buffer: RTL and testbench

//  Cell-resolution pixel store directly upstream of the VGA scan stage.
//  - Write side: accepts raster-ordered 12-bit pixels from the tracer core over a

---
 rtl/vga_fb_pkg.sv | 30 +++
 rtl/fb_ram.sv | 26 ++
 rtl/vga_frame_buffer.sv | 169 ++++++++++++++++
 tb/tb_vga_frame_buffer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
`default_nettype none
// =====================================================================
// vga_fb_pkg - cell geometry, pixel format and FSM encoding for the
// frame buffer. Rev 1.0
// =====================================================================
package vga_fb_pkg;

  // Must track the scan stage's UNIT_WIDTH so both sides agree on cell size.
  localparam int UNIT_WIDTH = 3;
  localparam int COLS       = 640 >> UNIT_WIDTH;
  localparam int ROWS       = 480 >> UNIT_WIDTH;
  localparam int COL_W      = 7;
  localparam int ROW_W      = 6;
  localparam int DATA_W     = 12;
  localparam int ADDR_W     = ROW_W + COL_W;

  localparam logic [DATA_W-1:0] CLR_COLOR = 12'h000;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_ram.sv
`default_nettype none
// =====================================================================
// fb_ram - single-write-port RAM with asynchronous read. Rev 1.0
// =====================================================================
module fb_ram #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/vga_frame_buffer.sv
`default_nettype none
// =====================================================================
// vga_frame_buffer - cell-resolution pixel store feeding the VGA scan
// stage; optional DOUBLE_BUFFER_EN adds a front/back bank pair. Rev 1.0
// =====================================================================
module vga_frame_buffer
  import vga_fb_pkg::*;
(
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_sof,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              busy,
  output logic              frame_done,
  input  logic              vs,
  input  logic [COL_W-1:0]  rd_col,
  input  logic [ROW_W-1:0]  rd_row,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  fb_state_t         state;
  logic [COL_W-1:0]  wcol, ccol;
  logic [ROW_W-1:0]  wrow, crow;
  logic              swap_pend, clr_pend, stall_nxt;
  logic              clr_start, accept, last_cell, clr_last;
  logic              we;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [DATA_W-1:0] wdata, rd_raw;

  assign clr_start = (state == IDLE) && (clr_req || clr_pend) && !swap_pend;
  // wr_ready is registered, so a clear starting this cycle vetoes the handshake here.
  assign accept    = wr_valid && wr_ready && !clr_start;
  assign last_cell = accept && !wr_sof && (wcol == LAST_COL) && (wrow == LAST_ROW);
  assign clr_last  = (state == CLEAR) && (ccol == LAST_COL) && (crow == LAST_ROW);

  always_comb begin
    we    = 1'b0;
    waddr = cell_addr(wrow, wcol);
    wdata = wr_data;
    if (state == CLEAR) begin
      we    = 1'b1;
      waddr = cell_addr(crow, ccol);
      wdata = CLR_COLOR;
    end else if (accept) begin
      we = 1'b1;
      if (wr_sof) waddr = '0;
    end
  end

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      wcol       <= '0;
      wrow       <= '0;
      ccol       <= '0;
      crow       <= '0;
    end else begin
      frame_done <= last_cell;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
            ccol     <= '0;
            crow     <= '0;
          end else begin
            wr_ready <= !stall_nxt;
            if (accept) begin
              if (wr_sof) begin
                wcol <= COL_W'(1);
                wrow <= '0;
              end else if (wcol == LAST_COL) begin
                wcol <= '0;
                wrow <= (wrow == LAST_ROW) ? '0 : wrow + 1'b1;
              end else begin
                wcol <= wcol + 1'b1;
              end
            end
          end
        end
        CLEAR: begin
          if (clr_last) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
            wcol     <= '0;
            wrow     <= '0;
          end else if (ccol == LAST_COL) begin
            ccol <= '0;
            crow <= crow + 1'b1;
          end else begin
            ccol <= ccol + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign raddr = cell_addr(rd_row, rd_col);

`ifdef DOUBLE_BUFFER_EN
  logic              vs_q, vs_fall, front;
  logic [DATA_W-1:0] rdata0, rdata1;

  assign vs_fall   = vs_q && !vs;
  assign stall_nxt = last_cell || (swap_pend && !vs_fall);

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      vs_q      <= 1'b1;
      swap_pend <= 1'b0;
      clr_pend  <= 1'b0;
      front     <= 1'b0;
    end else begin
      vs_q <= vs;
      if (last_cell) begin
        swap_pend <= 1'b1;
      end else if (swap_pend && vs_fall) begin
        swap_pend <= 1'b0;
        front     <= ~front;
      end
      // A clear requested while a swap is pending is remembered and run afterwards.
      if (clr_start)                clr_pend <= 1'b0;
      else if (clr_req && swap_pend) clr_pend <= 1'b1;
    end
  end

  fb_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
    .clk(vga_clk), .we(we && front), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata0)
  );
  fb_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
    .clk(vga_clk), .we(we && !front), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata1)
  );

  assign rd_raw = front ? rdata1 : rdata0;
`else
  logic              unused_vs;
  logic [DATA_W-1:0] rdata0;

  assign unused_vs = vs;
  assign swap_pend = 1'b0;
  assign clr_pend  = 1'b0;
  assign stall_nxt = 1'b0;

  fb_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
    .clk(vga_clk), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata0)
  );

  assign rd_raw = rdata0;
`endif

  assign rd_data = ((rd_col < COL_W'(COLS)) && (rd_row < ROW_W'(ROWS))) ? rd_raw : CLR_COLOR;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_buffer.sv
`default_nettype none
// =====================================================================
// tb_vga_frame_buffer - directed table-driven bench for vga_frame_buffer.
// Rev 1.0
// =====================================================================
module tb_vga_frame_buffer;
  import vga_fb_pkg::*;

  logic        vga_clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0, wr_sof = 1'b0, clr_req = 1'b0, vs = 1'b1;
  logic [11:0] wr_data = '0;
  logic [6:0]  rd_col = '0;
  logic [5:0]  rd_row = '0;
  logic        wr_ready, busy, frame_done;
  logic [11:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [6:0]  col;
    logic [5:0]  row;
    logic [11:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [10];

  always #5 vga_clk = ~vga_clk;

  vga_frame_buffer dut (
    .vga_clk(vga_clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sof(wr_sof), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy), .frame_done(frame_done), .vs(vs),
    .rd_col(rd_col), .rd_row(rd_row), .rd_data(rd_data)
  );

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_chk(input string name, input logic [6:0] col, input logic [5:0] row,
                          input logic [11:0] exp);
    rd_col = col;
    rd_row = row;
    #1;
    check(name, {20'd0, rd_data}, {20'd0, exp});
  endtask

  task automatic write_px(input logic [11:0] d, input logic sof);
    int n;
    n        = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_sof   = sof;
    while (!wr_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL wr_ready_timeout: got 0 expected 1");
    end
    tick();
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
  endtask

  task automatic wait_clear(input string name);
    int cnt;
    cnt = 0;
    while (busy && cnt < 6000) begin
      tick();
      cnt++;
    end
    check(name, cnt, 4800);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{7'd5,   6'd2,  12'h0A5};
    vecs[1] = '{7'd0,   6'd0,  12'h000};
    vecs[2] = '{7'd79,  6'd0,  12'h04F};
    vecs[3] = '{7'd0,   6'd1,  12'h050};
    vecs[4] = '{7'd79,  6'd59, 12'h2BF};
    vecs[5] = '{7'd79,  6'd51, 12'h03F};
    vecs[6] = '{7'd90,  6'd10, 12'h000};
    vecs[7] = '{7'd3,   6'd63, 12'h000};
    vecs[8] = '{7'd80,  6'd5,  12'h000};
    vecs[9] = '{7'd10,  6'd60, 12'h000};

    // reset behaviour
    repeat (3) tick();
    check("rst_wr_ready", {31'd0, wr_ready}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_frame_done", {31'd0, frame_done}, 0);
    rst = 1'b1;
    tick();
    check("post_rst_wr_ready", {31'd0, wr_ready}, 1);

`ifdef DOUBLE_BUFFER_EN
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wait_clear("db_clear1_cycles");
    for (int i = 0; i < 4800; i++) write_px(12'h123, 1'b0);
    check("db_frame_done", {31'd0, frame_done}, 1);
    check("db_stall", {31'd0, wr_ready}, 0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("db_clr_held_off", {31'd0, busy}, 0);
    vs = 1'b0;
    tick();
    vs = 1'b1;
    read_chk("db_swap1_read", 7'd0, 6'd0, 12'h123);
    check("db_busy_before_pending_clear", {31'd0, busy}, 0);
    tick();
    check("db_pending_clear_started", {31'd0, busy}, 1);
    wait_clear("db_clear2_cycles");
    check("db_ready_after_clear", {31'd0, wr_ready}, 1);
    for (int i = 0; i < 4800; i++) write_px(12'h0F0, 1'b0);
    check("db_stall2", {31'd0, wr_ready}, 0);
    repeat (5) tick();
    read_chk("db_unchanged_before_vs", 7'd40, 6'd30, 12'h123);
    check("db_still_stalled", {31'd0, wr_ready}, 0);
    vs = 1'b0;
    tick();
    read_chk("db_swap2_read", 7'd40, 6'd30, 12'h0F0);
    check("db_ready_after_swap", {31'd0, wr_ready}, 1);
    vs = 1'b1;
`else
    begin : t_frame
      int fd_count;
      fd_count = 0;
      for (int i = 0; i < 4800; i++) begin
        write_px(i[11:0], 1'b0);
        if (frame_done) fd_count++;
        if (i == 4798) check("frame_done_early", {31'd0, frame_done}, 0);
        if (i == 4799) check("frame_done_pulse", {31'd0, frame_done}, 1);
      end
      tick();
      check("frame_done_cleared", {31'd0, frame_done}, 0);
      check("frame_done_count", fd_count, 1);
    end

    for (int i = 0; i < 10; i++) begin
      read_chk($sformatf("rd_vec%0d", i), vecs[i].col, vecs[i].row, vecs[i].exp);
    end

    // start-of-frame resync from pointer (10,3)
    for (int i = 0; i < 250; i++) write_px(12'h111, 1'b0);
    write_px(12'hF00, 1'b1);
    write_px(12'h222, 1'b0);
    read_chk("sof_origin", 7'd0, 6'd0, 12'hF00);
    read_chk("sof_next_px", 7'd1, 6'd0, 12'h222);
    read_chk("sof_pointer_untouched", 7'd10, 6'd3, 12'h0FA);
    read_chk("sof_prior_px", 7'd9, 6'd3, 12'h111);

    // clear wins over a simultaneous pixel; re-request mid-clear is ignored
    begin : t_clear
      int cnt, nz;
      wr_valid = 1'b1;
      wr_data  = 12'hABC;
      clr_req  = 1'b1;
      tick();
      clr_req  = 1'b0;
      wr_valid = 1'b0;
      check("clr_busy", {31'd0, busy}, 1);
      check("clr_wr_ready", {31'd0, wr_ready}, 0);
      cnt = 0;
      while (busy && cnt < 6000) begin
        clr_req = (cnt == 100);
        tick();
        cnt++;
      end
      clr_req = 1'b0;
      check("clr_cycles", cnt, 4800);
      check("clr_done_ready", {31'd0, wr_ready}, 1);
      nz = 0;
      for (int r = 0; r < 60; r++) begin
        for (int c = 0; c < 80; c++) begin
          rd_row = r[5:0];
          rd_col = c[6:0];
          #1;
          if (rd_data !== 12'h000) nz++;
        end
      end
      check("clr_nonzero_cells", nz, 0);
    end

    // reset mid-clear aborts and rewinds the pointer
    for (int i = 0; i < 5; i++) write_px(12'h777, 1'b0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (1000) tick();
    #3 rst = 1'b0;
    #1;
    check("abort_busy_in_rst", {31'd0, busy}, 0);
    check("abort_ready_in_rst", {31'd0, wr_ready}, 0);
    tick();
    rst = 1'b1;
    tick();
    check("abort_busy_after", {31'd0, busy}, 0);
    check("abort_ready_after", {31'd0, wr_ready}, 1);
    write_px(12'h5A5, 1'b0);
    write_px(12'h6B6, 1'b0);
    read_chk("abort_first_px", 7'd0, 6'd0, 12'h5A5);
    read_chk("abort_second_px", 7'd1, 6'd0, 12'h6B6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
